// File: rtl/conv_pkg.sv
// Shared types for the convolution output path: the FIFO entry layout and the
// per-layer result count.
package conv_pkg;

    localparam int ENTRY_DATA_W  = 32;
    localparam int ENTRY_COORD_W = 32;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0]  data;
        logic [ENTRY_COORD_W-1:0] x;
        logic [ENTRY_COORD_W-1:0] y;
        logic [ENTRY_COORD_W-1:0] ch;
    } output_entry_t;

    function automatic logic [63:0] total_outputs(input int unsigned w,
                                                  input int unsigned h,
                                                  input int unsigned c);
        return 64'(w) * 64'(h) * 64'(c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and a synchronous flush
// that still accepts a same-cycle push as the first entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        // the write lands after any flush, so a flushing push becomes entry 0
        if (push) begin
            mem_d[wptr_d[IDX_W-1:0]] = wdata;
            wptr_d = wptr_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) && (wptr_q[IDX_W] != rptr_q[IDX_W]);
    assign level = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[IDX_W-1:0]];

endmodule

// File: rtl/conv_output_collector.sv
// Buffers finished output pixels from the MAC datapath and drains them to the
// host; tracks delivered count, last-of-layer, overflow and done.
module conv_output_collector
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int COORD_WIDTH        = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [COORD_WIDTH-1:0] in_x,
    input  logic [COORD_WIDTH-1:0] in_y,
    input  logic [COORD_WIDTH-1:0] in_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic [COORD_WIDTH-1:0] out_ch,
    output logic                   out_last,
    output logic [LVL_W-1:0]       fill_level,
    output logic                   overflow,
    output logic                   done
);

    localparam logic [63:0] TOTAL = total_outputs(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                                                  OUTPUT_NB_CHANNELS);

    output_entry_t wr_entry, rd_entry;
    logic          fifo_full, fifo_empty, push, pop;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic [63:0]   count_q, count_d;

    // entry fields are sized by the package; wider parameters are truncated
    always_comb begin
        wr_entry.data = ENTRY_DATA_W'(in_data);
        wr_entry.x    = ENTRY_COORD_W'(in_x);
        wr_entry.y    = ENTRY_COORD_W'(in_y);
        wr_entry.ch   = ENTRY_COORD_W'(in_ch);
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready && !start;
    assign push      = in_valid && (start || !fifo_full || pop);

    sync_fifo #(
        .WIDTH($bits(output_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .flush    (start),
        .push     (push),
        .pop      (pop),
        .wdata    (wr_entry),
        .rdata    (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fill_level)
    );

    always_comb begin
        overflow_d = overflow_q;
        done_d     = done_q;
        count_d    = count_q;
        if (start) begin
            overflow_d = 1'b0;
            done_d     = 1'b0;
            count_d    = '0;
        end else begin
            if (in_valid && fifo_full && !pop) overflow_d = 1'b1;
            if (pop && count_q != TOTAL) count_d = count_q + 64'd1;
            if (pop && count_q == TOTAL - 64'd1) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    assign overflow = overflow_q;
    assign done     = done_q;
    assign out_last = out_valid && (count_q == TOTAL - 64'd1);
    assign out_data = out_valid ? DATA_WIDTH'(rd_entry.data) : '0;
    assign out_x    = out_valid ? COORD_WIDTH'(rd_entry.x) : '0;
    assign out_y    = out_valid ? COORD_WIDTH'(rd_entry.y) : '0;
    assign out_ch   = out_valid ? COORD_WIDTH'(rd_entry.ch) : '0;

endmodule

// File: tb/tb_conv_output_collector.sv
// Scoreboard bench: instance a (depth 4) for directed tests, instance b
// (depth 8) for random-ready streaming; both sized for 8 results per layer.
module tb_conv_output_collector;

    typedef struct {
        logic [31:0] d;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n_in = 1'b0;

    logic        start_a = 0, in_valid_a = 0, out_ready_a = 0;
    logic [31:0] in_data_a = 0, in_x_a = 0, in_y_a = 0, in_ch_a = 0;
    logic        out_valid_a, out_last_a, overflow_a, done_a;
    logic [31:0] out_data_a, out_x_a, out_y_a, out_ch_a;
    logic [2:0]  fill_level_a;

    logic        start_b = 0, in_valid_b = 0, out_ready_b = 0;
    logic [31:0] in_data_b = 0, in_x_b = 0, in_y_b = 0, in_ch_b = 0;
    logic        out_valid_b, out_last_b, overflow_b, done_b;
    logic [31:0] out_data_b, out_x_b, out_y_b, out_ch_b;
    logic [3:0]  fill_level_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   dcnt_a = 0, dcnt_b = 0;
    int   total = 0, bad = 0;

    always #5 clk = ~clk;

    conv_output_collector #(
        .DATA_WIDTH(32), .COORD_WIDTH(32), .FIFO_DEPTH(4),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)
    ) dut_a (
        .clk(clk), .arst_n_in(arst_n_in), .start(start_a), .in_valid(in_valid_a),
        .in_data(in_data_a), .in_x(in_x_a), .in_y(in_y_a), .in_ch(in_ch_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_x(out_x_a), .out_y(out_y_a), .out_ch(out_ch_a), .out_last(out_last_a),
        .fill_level(fill_level_a), .overflow(overflow_a), .done(done_a)
    );

    conv_output_collector #(
        .DATA_WIDTH(32), .COORD_WIDTH(32), .FIFO_DEPTH(8),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)
    ) dut_b (
        .clk(clk), .arst_n_in(arst_n_in), .start(start_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_x(in_x_b), .in_y(in_y_b), .in_ch(in_ch_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_x(out_x_b), .out_y(out_y_b), .out_ch(out_ch_b), .out_last(out_last_b),
        .fill_level(fill_level_b), .overflow(overflow_b), .done(done_b)
    );

    // Sample handshakes on the falling edge, pop the scoreboard, then advance
    // to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid_a && out_ready_a && !start_a) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL sb_a_extra got data=%0d expected no entry", out_data_a);
            end else begin
                e = q_a.pop_front();
                if ({out_data_a, out_x_a, out_y_a, out_ch_a} !== {e.d, e.x, e.y, e.ch}) begin
                    bad++;
                    $display("FAIL sb_a_entry got d=%0d x=%0d y=%0d ch=%0d expected d=%0d x=%0d y=%0d ch=%0d",
                             out_data_a, out_x_a, out_y_a, out_ch_a, e.d, e.x, e.y, e.ch);
                end
                total++;
                if (out_last_a !== (dcnt_a == 7)) begin
                    bad++;
                    $display("FAIL sb_a_last got %0b expected %0b (d=%0d)", out_last_a, dcnt_a == 7, e.d);
                end
                dcnt_a++;
            end
        end
        if (out_valid_b && out_ready_b && !start_b) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL sb_b_extra got data=%0d expected no entry", out_data_b);
            end else begin
                e = q_b.pop_front();
                if ({out_data_b, out_x_b, out_y_b, out_ch_b} !== {e.d, e.x, e.y, e.ch}) begin
                    bad++;
                    $display("FAIL sb_b_entry got d=%0d x=%0d y=%0d ch=%0d expected d=%0d x=%0d y=%0d ch=%0d",
                             out_data_b, out_x_b, out_y_b, out_ch_b, e.d, e.x, e.y, e.ch);
                end
                total++;
                if (out_last_b !== (dcnt_b == 7)) begin
                    bad++;
                    $display("FAIL sb_b_last got %0b expected %0b (d=%0d)", out_last_b, dcnt_b == 7, e.d);
                end
                dcnt_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [31:0] d, input bit expect_accept);
        in_valid_a = 1'b1;
        in_data_a  = d;
        in_x_a     = d % 2;
        in_y_a     = (d / 2) % 2;
        in_ch_a    = d + 32'd1000;
        if (expect_accept) q_a.push_back('{d, d % 2, (d / 2) % 2, d + 32'd1000});
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic start_a_pulse();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        q_a.delete();
        dcnt_a = 0;
    endtask

    task automatic drain_a();
        out_ready_a = 1'b1;
        for (int k = 0; k < 40 && q_a.size() != 0; k++) tick();
        total++;
        if (q_a.size() != 0) begin
            bad++;
            $display("FAIL drain_a got %0d left expected 0", q_a.size());
        end
        total++;
        if (out_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL drain_a_empty got out_valid=%0b expected 0", out_valid_a);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid_a, out_last_a, overflow_a, done_a, fill_level_a, out_data_a} !== '0) begin
            bad++;
            $display("FAIL reset_a got v=%0b l=%0b ov=%0b dn=%0b fl=%0d d=%0d expected all 0",
                     out_valid_a, out_last_a, overflow_a, done_a, fill_level_a, out_data_a);
        end
        total++;
        if ({out_valid_b, overflow_b, done_b, fill_level_b, out_x_b, out_y_b, out_ch_b} !== '0) begin
            bad++;
            $display("FAIL reset_b got v=%0b ov=%0b dn=%0b fl=%0d expected all 0",
                     out_valid_b, overflow_b, done_b, fill_level_b);
        end
    endtask

    task automatic test_basic();
        out_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse_a(32'(10 + i), 1'b1);
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== 32'(10 + i)) begin
                bad++;
                $display("FAIL basic_latency got v=%0b d=%0d expected v=1 d=%0d",
                         out_valid_a, out_data_a, 10 + i);
            end
            if (i == 7) begin
                total++;
                if (out_last_a !== 1'b1 || done_a !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_last got last=%0b done=%0b expected last=1 done=0",
                             out_last_a, done_a);
                end
            end
            tick();
            if (i == 7) begin
                total++;
                if (done_a !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_done got %0b expected 1", done_a);
                end
            end
            tick();
        end
        total++;
        if (overflow_a !== 1'b0 || q_a.size() != 0) begin
            bad++;
            $display("FAIL basic_end got ov=%0b left=%0d expected ov=0 left=0", overflow_a, q_a.size());
        end
    endtask

    task automatic test_overflow();
        start_a_pulse();
        out_ready_a = 1'b0;
        for (int i = 1; i <= 4; i++) pulse_a(32'(i), 1'b1);
        total++;
        if (fill_level_a !== 3'd4 || out_data_a !== 32'd1) begin
            bad++;
            $display("FAIL ovf_full got fl=%0d d=%0d expected fl=4 d=1", fill_level_a, out_data_a);
        end
        tick();
        tick();
        total++;
        if (out_data_a !== 32'd1 || out_valid_a !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold got v=%0b d=%0d expected v=1 d=1", out_valid_a, out_data_a);
        end
        pulse_a(32'd5, 1'b0);
        total++;
        if (overflow_a !== 1'b1 || fill_level_a !== 3'd4) begin
            bad++;
            $display("FAIL ovf_drop got ov=%0b fl=%0d expected ov=1 fl=4", overflow_a, fill_level_a);
        end
        drain_a();
        total++;
        if (overflow_a !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got %0b expected 1", overflow_a);
        end
    endtask

    task automatic test_full_pop();
        start_a_pulse();
        out_ready_a = 1'b0;
        for (int i = 20; i < 24; i++) pulse_a(32'(i), 1'b1);
        out_ready_a = 1'b1;
        pulse_a(32'd24, 1'b1);
        total++;
        if (fill_level_a !== 3'd4 || overflow_a !== 1'b0) begin
            bad++;
            $display("FAIL full_pop got fl=%0d ov=%0b expected fl=4 ov=0", fill_level_a, overflow_a);
        end
        drain_a();
    endtask

    task automatic test_start();
        start_a_pulse();
        out_ready_a = 1'b0;
        for (int i = 30; i < 35; i++) pulse_a(32'(i), 1'b0);
        start_a_pulse();
        total++;
        if ({out_valid_a, fill_level_a, overflow_a, done_a, out_last_a} !== '0) begin
            bad++;
            $display("FAIL start_flush got v=%0b fl=%0d ov=%0b dn=%0b expected all 0",
                     out_valid_a, fill_level_a, overflow_a, done_a);
        end
        pulse_a(32'd40, 1'b0);
        pulse_a(32'd41, 1'b0);
        out_ready_a = 1'b1;
        start_a = 1'b1;
        q_a.delete();
        dcnt_a = 0;
        pulse_a(32'd99, 1'b1);
        start_a = 1'b0;
        total++;
        if (fill_level_a !== 3'd1 || out_valid_a !== 1'b1 || out_data_a !== 32'd99) begin
            bad++;
            $display("FAIL start_push got fl=%0d v=%0b d=%0d expected fl=1 v=1 d=99",
                     fill_level_a, out_valid_a, out_data_a);
        end
        drain_a();
    endtask

    task automatic test_random_b();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            in_valid_b  = 1'b1;
            in_data_b   = 32'(100 + i);
            in_x_b      = 32'(i % 2);
            in_y_b      = 32'((i / 2) % 2);
            in_ch_b     = 32'(i / 4);
            e           = '{in_data_b, in_x_b, in_y_b, in_ch_b};
            q_b.push_back(e);
            out_ready_b = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid_b = 1'b0;
        for (int k = 0; k < 200 && q_b.size() != 0; k++) begin
            out_ready_b = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready_b = 1'b0;
        total++;
        if (q_b.size() != 0 || overflow_b !== 1'b0 || done_b !== 1'b1) begin
            bad++;
            $display("FAIL random_b got left=%0d ov=%0b dn=%0b expected left=0 ov=0 dn=1",
                     q_b.size(), overflow_b, done_b);
        end
    endtask

    task automatic test_async_reset();
        start_a_pulse();
        out_ready_a = 1'b0;
        for (int i = 50; i < 55; i++) pulse_a(32'(i), 1'b0);
        total++;
        if (overflow_a !== 1'b1 || done_b !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre got ov_a=%0b dn_b=%0b expected 1 1", overflow_a, done_b);
        end
        #2;
        arst_n_in = 1'b0;
        #1;
        total++;
        if ({out_valid_a, overflow_a, fill_level_a, done_b, out_valid_b} !== '0) begin
            bad++;
            $display("FAIL arst_async got v=%0b ov=%0b fl=%0d dn_b=%0b expected all 0",
                     out_valid_a, overflow_a, fill_level_a, done_b);
        end
        #3;
        arst_n_in = 1'b1;
        q_a.delete();
        q_b.delete();
        dcnt_a = 0;
        dcnt_b = 0;
        @(posedge clk);
        #1;
        pulse_a(32'd7, 1'b1);
        total++;
        if (fill_level_a !== 3'd1 || out_data_a !== 32'd7) begin
            bad++;
            $display("FAIL arst_after got fl=%0d d=%0d expected fl=1 d=7", fill_level_a, out_data_a);
        end
        drain_a();
    endtask

    initial begin
        #3;
        test_reset();
        #9;
        arst_n_in = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_start();
        test_random_b();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
